// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX feeder FSM state encoding.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReq    = 3'd1,
    StWait   = 3'd2,
    StCsReq  = 3'd3,
    StCsWait = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with combinational read port (first word visible on pop_data).
// A push while full and a pop while empty are ignored. Pointers wrap modulo DEPTH.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CntOne    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntOne;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntOne;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus issue FSM feeding a UART transmitter one byte at a time:
// a 1-cycle tx_req with tx_data, then wait for tx_done before the next request.
// Define UART_TX_FEEDER_CSUM_EN to append an additive checksum byte after each
// byte pushed with wr_last; otherwise wr_last only produces frame_done.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_last,
  output logic                   wr_full,
  output logic                   wr_ovf,
  output logic                   tx_req,
  output logic [UART_BYTE_W-1:0] tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   frame_done
);

  tx_state_e                state_q, state_d;
  logic                     cur_last_q, cur_last_d;
  logic                     tx_req_q, tx_req_d;
  logic [UART_BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                     frame_done_q, frame_done_d;
  logic                     wr_ovf_q, wr_ovf_d;
`ifdef UART_TX_FEEDER_CSUM_EN
  logic [UART_BYTE_W-1:0]   csum_q, csum_d;
`endif

  logic                     fifo_pop;
  logic [UART_BYTE_W:0]     fifo_rdata;
  logic                     fifo_empty;
  logic [ADDR_W:0]          fifo_count;

  uart_sync_fifo #(
    .WIDTH  (UART_BYTE_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (wr_en),
    .push_data ({wr_last, wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (wr_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;
  assign wr_ovf     = wr_ovf_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (fifo_count != '0) state_d = StReq;
      StReq:  state_d = StWait;
      StWait: begin
        if (tx_done) begin
`ifdef UART_TX_FEEDER_CSUM_EN
          state_d = cur_last_q ? StCsReq : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef UART_TX_FEEDER_CSUM_EN
      StCsReq:  state_d = StCsWait;
      StCsWait: if (tx_done) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; tx_req is cleared by default so it lasts one cycle
  always_comb begin
    fifo_pop     = 1'b0;
    tx_req_d     = 1'b0;
    tx_data_d    = tx_data_q;
    cur_last_d   = cur_last_q;
    frame_done_d = 1'b0;
    wr_ovf_d     = wr_en && wr_full;
`ifdef UART_TX_FEEDER_CSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      StIdle: begin
        if (fifo_count != '0) begin
          fifo_pop   = 1'b1;
          tx_req_d   = 1'b1;
          tx_data_d  = fifo_rdata[UART_BYTE_W-1:0];
          cur_last_d = fifo_rdata[UART_BYTE_W];
        end
      end
      StWait: begin
        if (tx_done) begin
`ifdef UART_TX_FEEDER_CSUM_EN
          // Last byte keeps the running sum so the checksum state can send it
          csum_d = csum_q + tx_data_q;
`else
          frame_done_d = cur_last_q;
`endif
        end
      end
`ifdef UART_TX_FEEDER_CSUM_EN
      StCsReq: begin
        tx_req_d  = 1'b1;
        tx_data_d = csum_q;
      end
      StCsWait: begin
        if (tx_done) begin
          frame_done_d = 1'b1;
          csum_d       = '0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
      cur_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ovf_q     <= 1'b0;
`ifdef UART_TX_FEEDER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      cur_last_q   <= cur_last_d;
      frame_done_q <= frame_done_d;
      wr_ovf_q     <= wr_ovf_d;
`ifdef UART_TX_FEEDER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder. Models the transmitter (tx_done 20
// cycles after each tx_req) and adapts expectations to UART_TX_FEEDER_CSUM_EN.
module tb_uart_tx_feeder;

  localparam int DoneDelay = 20;
`ifdef UART_TX_FEEDER_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       wr_en     = 1'b0;
  logic [7:0] wr_data   = 8'h00;
  logic       wr_last   = 1'b0;
  logic       tx_done   = 1'b0;
  logic       wr_full, wr_ovf, tx_req, busy, frame_done;
  logic [7:0] tx_data;

  int checks   = 0;
  int failures = 0;

  logic       stall = 1'b0;
  logic       stray = 1'b0;
  logic [7:0] sent_q [$];
  int         fd_count = 0;
  int         cyc = 0;
  int         done_cyc = -100;
  logic       inflight = 1'b0;
  int         hold_cnt = 0;
  logic [7:0] inflight_data = 8'h00;

  typedef struct {
    int         n;
    logic [7:0] b [4];
    logic [7:0] cs;
  } vec_t;

  vec_t vecs [5];

  always #5 sys_clk = ~sys_clk;

  uart_tx_feeder #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_full    (wr_full),
    .wr_ovf     (wr_ovf),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model and monitor, on the falling edge
  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (frame_done === 1'b1) begin
      fd_count++;
      check("frame_done_after_tx_done", cyc, done_cyc + 1);
    end
    tx_done = stray;
    if (!sys_rst_n) begin
      inflight = 1'b0;
      hold_cnt = 0;
    end else if (tx_req === 1'b1) begin
      check("no_req_in_flight", {31'd0, inflight}, 32'd0);
      inflight      = 1'b1;
      hold_cnt      = 0;
      inflight_data = tx_data;
      sent_q.push_back(tx_data);
    end else if (inflight && !stall) begin
      hold_cnt++;
      if (hold_cnt == DoneDelay) begin
        check("tx_data_stable", {24'd0, tx_data}, {24'd0, inflight_data});
        tx_done  = 1'b1;
        inflight = 1'b0;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = l;
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    stall     = 1'b0;
    tick();
    tick();
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_wr_ovf", {31'd0, wr_ovf}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_wr_full", {31'd0, wr_full}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    sys_rst_n = 1'b1;
    tick();
  endtask

  // Waits for busy low, then one more cycle so the monitor sees any frame_done
  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic check_stream(input string name, input logic [7:0] exp_q [$]);
    logic [7:0] a;
    check({name, "_count"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
      check($sformatf("%s_byte%0d", name, i), {24'd0, a}, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    logic [7:0] exp_q [$];
    int fd0;
    int n;

    vecs[0].n = 1; vecs[0].b = '{8'h5A, 8'h00, 8'h00, 8'h00}; vecs[0].cs = 8'h5A;
    vecs[1].n = 3; vecs[1].b = '{8'h10, 8'h20, 8'hF5, 8'h00}; vecs[1].cs = 8'h25;
    vecs[2].n = 2; vecs[2].b = '{8'hFF, 8'h01, 8'h00, 8'h00}; vecs[2].cs = 8'h00;
    vecs[3].n = 4; vecs[3].b = '{8'h80, 8'h80, 8'h80, 8'h81}; vecs[3].cs = 8'h01;
    vecs[4].n = 1; vecs[4].b = '{8'h00, 8'h00, 8'h00, 8'h00}; vecs[4].cs = 8'h00;

    do_reset();

    // Latency: push at edge k, tx_req high only in the cycle after edge k+1
    sent_q.delete();
    fd0 = fd_count;
    push(8'h5A, 1'b1);
    check("lat_req_k", {31'd0, tx_req}, 32'd0);
    tick();
    check("lat_req_k1", {31'd0, tx_req}, 32'd1);
    check("lat_data_k1", {24'd0, tx_data}, 32'h5A);
    tick();
    check("lat_req_k2", {31'd0, tx_req}, 32'd0);
    wait_idle(200, "lat_idle");
    exp_q = '{8'h5A};
    if (CsumEn) exp_q.push_back(8'h5A);
    check_stream("lat", exp_q);
    check("lat_frame_done", fd_count - fd0, 1);

    // Table of single frames, back to back without reset so checksum clearing is exercised
    for (int v = 0; v < 5; v++) begin
      sent_q.delete();
      fd0 = fd_count;
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].b[i], (i == vecs[v].n - 1));
      wait_idle(400, $sformatf("vec%0d_idle", v));
      exp_q = {};
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].b[i]);
      if (CsumEn) exp_q.push_back(vecs[v].cs);
      check_stream($sformatf("vec%0d", v), exp_q);
      check($sformatf("vec%0d_frame_done", v), fd_count - fd0, 1);
    end

    // Overflow: one byte stuck in flight, then 17 pushes into the 16-entry FIFO
    do_reset();
    stall = 1'b1;
    sent_q.delete();
    fd0 = fd_count;
    push(8'hEE, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      wr_last = 1'b0;
      tick();
      if (i == 14) check("ovf_not_full_15", {31'd0, wr_full}, 32'd0);
      if (i == 15) begin
        check("ovf_full_16", {31'd0, wr_full}, 32'd1);
        check("ovf_no_pulse_16", {31'd0, wr_ovf}, 32'd0);
      end
      if (i == 16) check("ovf_pulse_17", {31'd0, wr_ovf}, 32'd1);
    end
    wr_en = 1'b0;
    tick();
    check("ovf_pulse_end", {31'd0, wr_ovf}, 32'd0);
    stall = 1'b0;
    wait_idle(700, "ovf_idle");
    exp_q = '{8'hEE};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    check_stream("ovf", exp_q);
    check("ovf_no_frame_done", fd_count - fd0, 0);

    // Steady flow-controlled stream of 50 bytes; pointers wrap about three times
    do_reset();
    sent_q.delete();
    fd0 = fd_count;
    for (int i = 0; i < 50; i++) begin
      n = 0;
      while (wr_full === 1'b1 && n < 100) begin
        tick();
        n++;
      end
      push(8'(i), (i == 49));
    end
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    // Sampled just after the edge ending the tx_done cycle, before the monitor's next count
    check("wrap_busy_drop", cyc, done_cyc);
    tick();
    exp_q = {};
    for (int i = 0; i < 50; i++) exp_q.push_back(8'(i));
    if (CsumEn) exp_q.push_back(8'hC9);
    check_stream("wrap", exp_q);
    check("wrap_frame_done", fd_count - fd0, 1);

    // Reset while waiting on a byte with five more queued
    stall = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i), (i == 5));
    tick();
    tick();
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    sys_rst_n = 1'b0;
    tick();
    check("midrst_tx_req", {31'd0, tx_req}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wr_full", {31'd0, wr_full}, 32'd0);
    sys_rst_n = 1'b1;
    stall     = 1'b0;
    tick();
    sent_q.delete();
    fd0 = fd_count;
    push(8'hA5, 1'b1);
    wait_idle(200, "midrst_idle");
    exp_q = '{8'hA5};
    if (CsumEn) exp_q.push_back(8'hA5);
    check_stream("midrst", exp_q);
    check("midrst_frame_done", fd_count - fd0, 1);

    // Stray tx_done while idle must change nothing
    fd0 = fd_count;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    tick();
    tick();
    check("stray_busy", {31'd0, busy}, 32'd0);
    check("stray_tx_req", {31'd0, tx_req}, 32'd0);
    check("stray_frame_done", fd_count - fd0, 0);
    sent_q.delete();
    fd0 = fd_count;
    push(8'h33, 1'b1);
    wait_idle(200, "stray_idle");
    exp_q = '{8'h33};
    if (CsumEn) exp_q.push_back(8'h33);
    check_stream("stray", exp_q);
    check("stray_frame_after", fd_count - fd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
